// File: rtl/abr_params_pkg.sv
// Shared parameters and share typedefs for the masked two-share datapath.
package abr_params_pkg;

  localparam int NUM_SHARES  = 2;
  localparam int SHARE_WIDTH = 8;

  // One bit position of a bit-sliced value: bit s belongs to share s.
  typedef logic [NUM_SHARES-1:0] sliced_bit_t;

  typedef logic [NUM_SHARES-1:0][SHARE_WIDTH-1:0] packed_shares_t;

endpackage

// File: rtl/abr_masked_two_share_collector_if.sv
// Producer and consumer handshake bundle of the two-share collector.
interface abr_masked_two_share_collector_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import abr_params_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                               in_valid;
  logic                               in_ready;
  sliced_bit_t                        in_z [WIDTH];
  logic [WIDTH-1:0]                   random;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_SHARES-1:0][WIDTH-1:0]   out_shares;
  logic [CW-1:0]                      out_count;

  modport master (
    output in_valid, in_z, random, out_ready,
    input  in_ready, out_valid, out_shares, out_count
  );

  modport slave (
    input  in_valid, in_z, random, out_ready,
    output in_ready, out_valid, out_shares, out_count
  );

endinterface

// File: rtl/abr_masked_share_fifo.sv
// In-order FIFO of packed share pairs with synchronous zeroize.
module abr_masked_share_fifo
  import abr_params_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             zeroize_i,
  input  logic                             push_i,
  input  logic [NUM_SHARES-1:0][WIDTH-1:0] push_data_i,
  input  logic                             pop_i,
  output logic                             valid_o,
  output logic [NUM_SHARES-1:0][WIDTH-1:0] data_o,
  output logic [$clog2(DEPTH):0]           count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_SHARES-1:0][WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  assign valid_o = (count_q != '0);
  assign pop     = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // DEPTH is a power of two, so the pointer increment wraps on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (zeroize_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/abr_masked_two_share_collector.sv
// Repacks bit-sliced two-share input, refreshes the masking with a fresh random,
// and queues the re-masked pair in an output FIFO.
module abr_masked_two_share_collector
  import abr_params_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                               clk,
  input logic                               rst_n,
  input logic                               zeroize,
  abr_masked_two_share_collector_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

  logic [NUM_SHARES-1:0][WIDTH-1:0] packed_in, stage_d, stage_q, fifo_data;
  logic                             stage_valid_d, stage_valid_q;
  logic                             accept, fifo_valid;
  logic [CW-1:0]                    fifo_count;
  logic [CW:0]                      pending;

  always_comb begin
    packed_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int s = 0; s < NUM_SHARES; s++) packed_in[s][i] = bus.in_z[i][s];
    end
  end

  // The staged entry counts against capacity, so the FIFO can never overflow.
  assign pending      = {1'b0, fifo_count} + {{CW{1'b0}}, stage_valid_q};
  assign bus.in_ready = (pending < DepthW);
  assign accept       = bus.in_valid & bus.in_ready;

  // Re-masking never forms the unmasked sum: each share is offset independently.
  always_comb begin
    stage_d       = stage_q;
    stage_valid_d = accept;
    if (accept) begin
      stage_d[0] = packed_in[0] + bus.random;
      stage_d[1] = packed_in[1] - bus.random;
    end
    if (zeroize) begin
      stage_d       = '0;
      stage_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
    end
  end

  abr_masked_share_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .zeroize_i   (zeroize),
    .push_i      (stage_valid_q),
    .push_data_i (stage_q),
    .pop_i       (bus.out_ready),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .count_o     (fifo_count)
  );

  assign bus.out_valid  = fifo_valid;
  assign bus.out_shares = fifo_data;
  assign bus.out_count  = fifo_count;

endmodule

// File: doc/abr_masked_two_share_collector.md
ABR_MASKED_TWO_SHARE_COLLECTOR -- requirements
Module: abr_masked_two_share_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of each arithmetic share.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the output FIFO entry count; power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 zeroize  input  1  synchronous clear of all state.
REQ-006 in_valid  input  1  producer offers one share pair this cycle.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 in_z  input  [1:0] x WIDTH, unpacked  bit-sliced two-share input; in_z[i][s] is bit i of share s (multiplier output format).
REQ-009 random  input  WIDTH  fresh refresh mask, sampled only on an accepted transfer.
REQ-010 out_valid  output  1  head FIFO entry is presented.
REQ-011 out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 out_shares  output  [1:0][WIDTH-1:0]  packed arithmetic shares; out_shares[s] is share s.
REQ-013 out_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 Transfer: accept occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-015 Repack: packed share s bit i SHALL equal in_z[i][s].
REQ-016 Refresh stage: on accept, the stage register SHALL load share0 + random and share1 - random (mod 2^WIDTH), and stage_valid SHALL be set to 1.
REQ-017 Stage without accept: stage_valid SHALL clear to 0 in any cycle with no accept.
REQ-018 Stage drain: when stage_valid is 1, the stage contents SHALL be written into the FIFO on the next edge, unconditionally.
REQ-019 Flow control: in_ready SHALL be (out_count + stage_valid) < DEPTH and SHALL NOT depend combinationally on out_ready or in_valid; FIFO overflow is therefore impossible.
REQ-020 Latency: data accepted at edge k SHALL be presented with out_valid=1 after edge k+1 if the FIFO was empty, giving 2-cycle latency; full throughput is 1 pair/cycle while the consumer drains.
REQ-021 FIFO output: out_valid = (out_count != 0); out_shares SHALL be the head entry, and SHALL be 0 when empty.
REQ-022 Pop: the head entry is popped when out_valid and out_ready are both 1; out_ready while empty SHALL be ignored.
REQ-023 Simultaneous push and pop: out_count SHALL be unchanged, and both pointers SHALL advance.
REQ-024 Pointers: read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Ordering: output SHALL be strictly in order of acceptance.
REQ-026 Correctness: out_shares[0] + out_shares[1] mod 2^WIDTH SHALL equal the input share sum.
REQ-027 Unmasking: no single register or output SHALL hold the unmasked sum.
REQ-028 Zeroize: zeroize SHALL clear stage, FIFO storage, pointers and count on the next edge, with priority over push and pop; any in-flight transfer is dropped.

Reset
REQ-029 While rst_n=0, all registers SHALL be 0; out_valid=0, out_count=0, out_shares=0, and in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all pending data immediately (asynchronous).

Structure
REQ-031 The share count (2) and the bit-sliced and packed share typedefs SHALL live in the shared abr_params_pkg.
REQ-032 The FIFO SHALL be one sub-module, abr_masked_share_fifo, parameterised by WIDTH and DEPTH, with synchronous zeroize.
REQ-033 The refresh stage SHALL remain in the top module.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Refresh: accept in_z shares (0x30, 0x05) with random=0x11 -> two cycles later out_shares=(0x41, 0xF4), and the sum is 0x35.
REQ-035 Wrap-around: shares (0xFF, 0x02) with random=0x03 -> out_shares=(0x02, 0xFF), and the sum is 0x01.
REQ-036 Backpressure: out_ready=0 with continuous in_valid -> in_ready falls after 4 accepts; out_count=4, out_valid=1 with the first pair at the head; no loss.
REQ-037 Full drain-and-fill: FIFO full, out_ready=1 and in_valid=1 for 10 cycles -> in-order output; out_count never exceeds 4; share sums are preserved.
REQ-038 Zeroize: zeroize with 3 entries queued and stage_valid=1 -> next cycle out_count=0, out_valid=0, out_shares=0; a subsequent accept emerges after 2 cycles.
REQ-039 Async reset: rst_n asserted between clock edges while full -> outputs are 0 immediately; after release, in_ready=1.
